shift_arb_ctrl: RTL

SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

---
 rtl/shift_arb_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/shift_arb_ctrl.sv
// Two-requester serial shifter: round-robin grant, WIDTH-bit full-duplex frame,
// captured receive word presented on rx_data at end of frame.
module shift_arb_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             dir_a,
  input  logic             dir_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sin,
  output logic             sout,
  output logic             frame_en,
  output logic             grant_a,
  output logic             grant_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dir_r;
  logic             last_b;
  logic             pick_a;

  // A wins when alone, or on a tie when B was the last one served
  assign pick_a = req_a & (~req_b | last_b);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      dir_r    <= 1'b0;
      last_b   <= 1'b1;
      sout     <= 1'b0;
      frame_en <= 1'b0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a | req_b) begin
            grant_a <= pick_a;
            grant_b <= ~pick_a;
            shreg   <= pick_a ? data_a : data_b;
            dir_r   <= pick_a ? dir_a : dir_b;
            last_b  <= ~pick_a;
            state   <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          frame_en <= 1'b1;
          if (dir_r) begin
            sout  <= shreg[WIDTH-1];
            shreg <= {shreg[WIDTH-2:0], sin};
          end else begin
            sout  <= shreg[0];
            shreg <= {sin, shreg[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          sout     <= 1'b0;
          frame_en <= 1'b0;
          done     <= 1'b1;
          rx_data  <= shreg;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
